add_4: RTL and testbench

// - WIDTH-bit ripple-carry adder with carry-in and carry-out. Default WIDTH is 4.
// - Combinational result path: sum/cout settle within the same timestep as the inputs,

---
 rtl/add_4.sv | 80 ++++++++
 tb/tb_add_4.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/add_4.sv
// add_4 -- WIDTH-bit ripple-carry adder with carry-in/carry-out and a
// registered copy of the result.
//
// The combinational path (sum, cout) is a structural chain of WIDTH full
// adders with no clock dependency. The registered path (sum_q, cout_q) loads
// the current combinational result on a rising clk when en is high. It is
// cleared asynchronously by reset.
//
// Optional feature macro: ADD_4_OVF_EN
//   When defined, the module adds the output port ovf. This port reports the
//   two's-complement overflow of a+b+cin as c[WIDTH]^c[WIDTH-1]. When the macro
//   is undefined, neither the port nor the logic exists.
//
// Parameters:
//   WIDTH   operand/sum width in bits, legal range 1..32 (default 4)
//
// Ports:
//   clk     in   1      rising-edge clock, used only by the registered outputs
//   reset   in   1      asynchronous active-high clear of sum_q/cout_q
//   a       in   WIDTH  operand A, unsigned
//   b       in   WIDTH  operand B, unsigned
//   cin     in   1      carry in
//   en      in   1      load enable for sum_q/cout_q
//   sum     out  WIDTH  combinational (a+b+cin) mod 2^WIDTH
//   cout    out  1      combinational carry out
//   sum_q   out  WIDTH  registered sum
//   cout_q  out  1      registered cout
//   ovf     out  1      combinational signed overflow (ADD_4_OVF_EN only)

module add_4 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             en,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [WIDTH-1:0] sum_q,
  output logic             cout_q
`ifdef ADD_4_OVF_EN
  ,
  output logic             ovf
`endif
);

  // Carry chain: c[0] is the carry in, and c[WIDTH] is the carry out.
  logic [WIDTH:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    logic p;
    // p is the propagate term; it is shared by the sum and carry equations.
    assign p        = a[i] ^ b[i];
    assign sum[i]   = p ^ c[i];
    assign c[i + 1] = (a[i] & b[i]) | (c[i] & p);
  end

  assign cout = c[WIDTH];

`ifdef ADD_4_OVF_EN
  // Signed overflow occurs when the carry into the MSB differs from the carry out of it.
  assign ovf = c[WIDTH] ^ c[WIDTH-1];
`endif

  // Registered copy. Reset has priority over a coincident enabled edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else if (en) begin
      sum_q  <= sum;
      cout_q <= cout;
    end
  end

endmodule

// File: tb/tb_add_4.sv
// tb_add_4 -- directed bench for add_4 at the default WIDTH of 4.
// The bench first sweeps the combinational path exhaustively. It then tests
// the boundary sums, the registered-path latency, the enable hold behaviour,
// and the asynchronous reset. The overflow checks are built only when
// ADD_4_OVF_EN is defined.

module tb_add_4;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] a, b;
  logic       cin, en;
  logic [3:0] sum, sum_q;
  logic       cout, cout_q;
`ifdef ADD_4_OVF_EN
  logic       ovf;
`endif

  always #5 clk = ~clk;

  add_4 #(.WIDTH(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .a      (a),
    .b      (b),
    .cin    (cin),
    .en     (en),
    .sum    (sum),
    .cout   (cout),
    .sum_q  (sum_q),
    .cout_q (cout_q)
`ifdef ADD_4_OVF_EN
    ,
    .ovf    (ovf)
`endif
  );

  // ---------------- scoreboard ----------------
  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic [3:0] va, input logic [3:0] vb,
                       input logic vcin, input logic ven);
    a   = va;
    b   = vb;
    cin = vcin;
    en  = ven;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [4:0] full;
    reset = 1'b1;
    drive(4'd5, 4'd6, 1'b1, 1'b1);
    #2;
    // The registered outputs must stay cleared while reset is held, including across clock edges.
    check("reset_sum_q", 32'(sum_q), 32'd0);
    check("reset_cout_q", 32'(cout_q), 32'd0);
    // The combinational path is live during reset: 5+6+1=12.
    check("reset_comb_sum", 32'(sum), 32'd12);
    @(posedge clk);
    #1;
    check("reset_hold_sum_q", 32'(sum_q), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    en    = 1'b0;

    // Exhaustive sweep of the combinational path
    for (int i = 0; i < 512; i++) begin
      a   = 4'(i >> 5);
      b   = 4'(i >> 1);
      cin = i[0];
      #1;
      full = 5'(a) + 5'(b) + 5'(cin);
      check("exh_sum", 32'(sum), 32'(full[3:0]));
      check("exh_cout", 32'(cout), 32'(full[4]));
    end
    // en was low for the whole sweep, so the registered outputs must still be 0.
    check("exh_no_load", 32'(sum_q), 32'd0);

    // Boundary cases
    drive(4'd15, 4'd15, 1'b1, 1'b0); #1;
    check("wrap_sum", 32'(sum), 32'd15);
    check("wrap_cout", 32'(cout), 32'd1);
    drive(4'd15, 4'd0, 1'b1, 1'b0); #1;
    check("f0c_sum", 32'(sum), 32'd0);
    check("f0c_cout", 32'(cout), 32'd1);
    drive(4'd0, 4'd0, 1'b0, 1'b0); #1;
    check("zero_sum", 32'(sum), 32'd0);
    check("zero_cout", 32'(cout), 32'd0);
    drive(4'd0, 4'd0, 1'b1, 1'b0); #1;
    check("cin_sum", 32'(sum), 32'd1);
    check("cin_cout", 32'(cout), 32'd0);

    // Registered latency: 7+8+1 = 16, giving sum_q=0 and cout_q=1 after one edge.
    @(negedge clk);
    drive(4'd7, 4'd8, 1'b1, 1'b1);
    #1;
    check("lat_before_cout_q", 32'(cout_q), 32'd0);
    @(posedge clk);
    #1;
    check("lat_sum_q", 32'(sum_q), 32'd0);
    check("lat_cout_q", 32'(cout_q), 32'd1);

    // Enable hold: load 3+4+0 = 7, then hold for three edges with en low.
    @(negedge clk);
    drive(4'd3, 4'd4, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    check("load7_sum_q", 32'(sum_q), 32'd7);
    check("load7_cout_q", 32'(cout_q), 32'd0);
    @(negedge clk);
    drive(4'd9, 4'd9, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check("hold_sum_q", 32'(sum_q), 32'd7);
      check("hold_cout_q", 32'(cout_q), 32'd0);
    end
    // The combinational result is 9+9 = 18, giving sum=2 and cout=1.
    check("hold_comb_sum", 32'(sum), 32'd2);
    check("hold_comb_cout", 32'(cout), 32'd1);

    // Async reset pulse between clock edges
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("async_sum_q", 32'(sum_q), 32'd0);
    check("async_cout_q", 32'(cout_q), 32'd0);
    check("async_comb_sum", 32'(sum), 32'd2);
    #1;
    reset = 1'b0;

    // After reset is released, the next enabled edge loads normally: 5+6+0 = 11.
    drive(4'd5, 4'd6, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    check("post_reset_sum_q", 32'(sum_q), 32'd11);

    // Reset asserted at the same instant as an enabled edge: reset wins.
    @(negedge clk);
    drive(4'd1, 4'd1, 1'b0, 1'b1);
    @(posedge clk);
    reset = 1'b1;
    #1;
    check("coincident_sum_q", 32'(sum_q), 32'd0);
    check("coincident_cout_q", 32'(cout_q), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("after_coincident_sum_q", 32'(sum_q), 32'd2);

`ifdef ADD_4_OVF_EN
    drive(4'd7, 4'd1, 1'b0, 1'b0); #1;
    check("ovf_7p1", 32'(ovf), 32'd1);
    drive(4'd8, 4'd8, 1'b0, 1'b0); #1;
    check("ovf_8p8", 32'(ovf), 32'd1);
    check("ovf_8p8_cout", 32'(cout), 32'd1);
    drive(4'd3, 4'd2, 1'b0, 1'b0); #1;
    check("ovf_3p2", 32'(ovf), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
